// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// single-outstanding req/gnt/rvalid memory port, and hands it to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] jalr_target,
  output logic        fetch_fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_next;
  logic [31:0] pc_next, instr_next, retired_next, target;
  logic        fault_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr       <= NOP;
      retired     <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      retired     <= retired_next;
      fetch_fault <= fault_next;
    end
  end

  // Reserved select 11 falls through to the sequential pc+4 path.
  always_comb begin
    target = pc + 32'd4;
    case (pc_src)
      2'b01:   target = pc + imm_ext;
      2'b10:   target = jalr_target & ~32'd1;
      default: target = pc + 32'd4;
    endcase
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    instr_next   = instr;
    retired_next = retired;
    fault_next   = fetch_fault;
    case (state)
      REQ: begin
        if (imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_next      = target;
          retired_next = retired + 32'd1;
          if (target[1:0] == 2'b00) begin
            state_next = REQ;
          end else begin
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end
      end
      default: state_next = FAULT;
    endcase
  end

  // Handshake outputs decode straight from the state so async reset shows at once.
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7_5    = instr[30];

endmodule
